mio_bus_ctrl: RTL and testbench

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

---
 rtl/mio_bus_ctrl.sv | 143 ++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: decodes one CPU access at a time onto one of NSLV slave channels.
// Define MIO_TIMEOUT_EN to abort an ACCESS that sees no ready within TIMEOUT cycles.
module mio_bus_ctrl #(
  parameter int                NSLV    = 4,
  parameter int                SLV_AW  = 16,
  parameter logic [4*NSLV-1:0] DEC_NIB = {4'hF, 4'hE, 4'hD, 4'h0},
  parameter int                TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  input  logic [3:0]         cpu_be,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_err,
  output logic [NSLV-1:0]    slv_sel,
  output logic               slv_we,
  output logic [SLV_AW-1:0]  slv_addr,
  output logic [31:0]        slv_wdata,
  output logic [3:0]         slv_be,
  input  logic [32*NSLV-1:0] slv_rdata,
  input  logic [NSLV-1:0]    slv_ready,
  output logic [31:0]        err_addr,
  output logic [7:0]         err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("mio_bus_ctrl: NSLV or TIMEOUT out of range");
  end

  logic [1:0]      state_q;
  logic [NSLV-1:0] sel_q;
  logic [31:0]     addr_q;
  logic [31:0]     rdata_q;
  logic [NSLV-1:0] dec_sel;
  logic            dec_hit;
  logic [31:0]     rd_mux;
  logic            ready_hit;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (!dec_hit && cpu_addr[31:28] == DEC_NIB[4*k +: 4]) begin
        dec_sel[k] = 1'b1;
        dec_hit    = 1'b1;
      end
    end
  end

  // sel_q is one-hot, so OR-ing the gated lanes selects the owning channel only.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) rd_mux = rd_mux | slv_rdata[32*k +: 32];
    end
  end

  assign ready_hit = |(slv_ready & sel_q);
  assign slv_sel   = (state_q == S_ACCESS) ? sel_q : '0;
  assign slv_addr  = addr_q[SLV_AW-1:0];

`ifdef MIO_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      slv_we    <= 1'b0;
      slv_wdata <= '0;
      slv_be    <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      err_addr  <= '0;
      err_cnt   <= '0;
`ifdef MIO_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            slv_we    <= cpu_we;
            addr_q    <= cpu_addr;
            slv_wdata <= cpu_wdata;
            slv_be    <= cpu_be;
            sel_q     <= dec_sel;
            state_q   <= dec_hit ? S_ACCESS : S_ERR;
`ifdef MIO_TIMEOUT_EN
            tmo_q     <= '0;
`endif
          end
        end
        S_ACCESS: begin
          // Ready on the expiry cycle still completes normally.
          if (ready_hit) begin
            rdata_q <= slv_we ? 32'h0 : rd_mux;
            state_q <= S_RESP;
          end
`ifdef MIO_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        S_RESP: begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= rdata_q;
          state_q   <= S_IDLE;
        end
        S_ERR: begin
          cpu_ack   <= 1'b1;
          cpu_err   <= 1'b1;
          cpu_rdata <= 32'h0;
          err_addr  <= addr_q;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: randomized self-checking bench for mio_bus_ctrl against a
// transaction-level model (decode table, latency formula, error counters).
module tb_mio_bus_ctrl;

  localparam int                NSLV   = 4;
  localparam int                SLV_AW = 16;
  localparam logic [4*NSLV-1:0] DEC    = {4'hF, 4'hE, 4'hD, 4'h0};
  localparam int                TMO    = 4;
`ifdef MIO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               cpu_req;
  logic               cpu_we;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic [3:0]         cpu_be;
  logic [31:0]        cpu_rdata;
  logic               cpu_ack;
  logic               cpu_err;
  logic [NSLV-1:0]    slv_sel;
  logic               slv_we;
  logic [SLV_AW-1:0]  slv_addr;
  logic [31:0]        slv_wdata;
  logic [3:0]         slv_be;
  logic [32*NSLV-1:0] slv_rdata;
  logic [NSLV-1:0]    slv_ready;
  logic [31:0]        err_addr;
  logic [7:0]         err_cnt;

  int          total;
  int          bad;
  int          m_err_cnt;
  logic [31:0] m_err_addr;
  logic [31:0] m_rdata;

  mio_bus_ctrl #(
    .NSLV(NSLV), .SLV_AW(SLV_AW), .DEC_NIB(DEC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_be(slv_be),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .err_addr(err_addr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel owning an address: lowest index whose nibble matches, -1 if none.
  function automatic int decode(input logic [31:0] a);
    logic [4*NSLV-1:0] nib;
    nib = DEC;
    for (int k = 0; k < NSLV; k++)
      if (a[31:28] == nib[4*k +: 4]) return k;
    return -1;
  endfunction

  task automatic rand_rdata();
    for (int j = 0; j < NSLV; j++) slv_rdata[32*j +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_req   = 1'b0;
      slv_ready = NSLV'($urandom);
      rand_rdata();
      step();
      total++;
      if (cpu_ack !== 1'b0 || cpu_err !== 1'b0 || slv_sel !== '0 || cpu_rdata !== m_rdata) begin
        bad++;
        $display("FAIL idle: ack=%b err=%b sel=%b rdata=%h, want 0 0 0 %h",
                 cpu_ack, cpu_err, slv_sel, cpu_rdata, m_rdata);
      end
    end
    slv_ready = '0;
  endtask

  // One complete transaction; ready on ACCESS cycle wait_c+1. Called from IDLE, returns at the ack sample.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int wait_c, input bit fix_rd,
                         input logic [31:0] rd_val, input bit noise);
    int              k;
    int              exp_acc;
    int              exp_lat;
    int              cyc;
    bit              exp_err;
    logic [31:0]     exp_rd;
    logic [NSLV-1:0] exp_sel;
    logic [NSLV-1:0] want_sel;
    logic [SLV_AW+36:0] exp_fld;
    k       = decode(addr);
    exp_sel = '0;
    if (k >= 0) exp_sel[k] = 1'b1;
    exp_fld = {we, addr[SLV_AW-1:0], wdata, be};
    exp_rd  = 32'h0;
    if (k < 0) begin
      exp_err = 1'b1; exp_acc = 0; exp_lat = 1;
    end else if (TMO_EN && wait_c >= TMO) begin
      exp_err = 1'b1; exp_acc = TMO; exp_lat = TMO + 1;
    end else begin
      exp_err = 1'b0; exp_acc = wait_c + 1; exp_lat = wait_c + 2;
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    slv_ready = '0;
    step();
    cyc = 0;
    while (cpu_ack !== 1'b1 && cyc <= exp_lat + 2) begin
      want_sel = (cyc < exp_acc) ? exp_sel : '0;
      total++;
      if (slv_sel !== want_sel) begin
        bad++;
        $display("FAIL sel: addr=%h cyc=%0d got=%b want=%b", addr, cyc, slv_sel, want_sel);
      end
      if (cyc < exp_acc) begin
        total++;
        if ({slv_we, slv_addr, slv_wdata, slv_be} !== exp_fld) begin
          bad++;
          $display("FAIL fields: addr=%h got we=%b a=%h d=%h be=%h want %h",
                   addr, slv_we, slv_addr, slv_wdata, slv_be, exp_fld);
        end
      end
      rand_rdata();
      slv_ready = noise ? NSLV'($urandom) : '0;
      if (k >= 0) slv_ready[k] = 1'b0;
      if (k >= 0 && !exp_err && cyc == exp_acc - 1) begin
        slv_ready[k] = 1'b1;
        if (fix_rd) slv_rdata[32*k +: 32] = rd_val;
        exp_rd = we ? 32'h0 : slv_rdata[32*k +: 32];
      end
      if (noise) begin
        cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
        cpu_wdata = $urandom; cpu_be = 4'($urandom);
      end
      step();
      cyc++;
    end
    cpu_req = 1'b0;
    slv_ready = '0;
    total++;
    if (cpu_ack !== 1'b1 || cyc != exp_lat) begin
      bad++;
      $display("FAIL latency: addr=%h ack=%b after %0d edges, want ack after %0d",
               addr, cpu_ack, cyc, exp_lat);
    end
    if (exp_err) begin
      m_err_addr = addr;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    m_rdata = exp_rd;
    total++;
    if (cpu_err !== exp_err || cpu_rdata !== exp_rd) begin
      bad++;
      $display("FAIL resp: addr=%h got err=%b rdata=%h want err=%b rdata=%h",
               addr, cpu_err, cpu_rdata, exp_err, exp_rd);
    end
    total++;
    if (err_cnt !== 8'(m_err_cnt) || err_addr !== m_err_addr) begin
      bad++;
      $display("FAIL errlog: got cnt=%0d addr=%h want cnt=%0d addr=%h",
               err_cnt, err_addr, m_err_cnt, m_err_addr);
    end
    total++;
    if (slv_sel !== '0) begin
      bad++;
      $display("FAIL sel_at_ack: got=%b want=0", slv_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    slv_rdata = '0; slv_ready = '0;
    m_err_cnt = 0; m_err_addr = '0; m_rdata = '0;
    #2 rst = 1'b0;
    #1;
    total++;
    if (cpu_ack !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_cpu: ack=%b err=%b rdata=%h want 0 0 0", cpu_ack, cpu_err, cpu_rdata);
    end
    total++;
    if (slv_sel !== '0 || slv_we !== 1'b0 || slv_addr !== '0 || slv_wdata !== '0 || slv_be !== '0) begin
      bad++;
      $display("FAIL reset_slv: sel=%b we=%b a=%h d=%h be=%h want all 0",
               slv_sel, slv_we, slv_addr, slv_wdata, slv_be);
    end
    total++;
    if (err_addr !== 32'h0 || err_cnt !== 8'h0) begin
      bad++;
      $display("FAIL reset_err: addr=%h cnt=%0d want 0 0", err_addr, err_cnt);
    end
    step();
    step();
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_read();
    run_txn(1'b0, 32'hD000_0004, 32'h0, 4'hF, 0, 1'b1, 32'h1234_5678, 1'b0);
    total++;
    if (cpu_rdata !== 32'h1234_5678 || cpu_err !== 1'b0) begin
      bad++;
      $display("FAIL read_d: rdata=%h err=%b want 12345678 0", cpu_rdata, cpu_err);
    end
    idle(1);
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 3, 1'b0, 32'h0, 1'b1);
    total++;
    if (cpu_rdata !== 32'h0 || cpu_err !== 1'b0) begin
      bad++;
      $display("FAIL write_d: rdata=%h err=%b want 0 0", cpu_rdata, cpu_err);
    end
    idle(1);
  endtask

  task automatic test_decode_err();
    run_txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b1);
    total++;
    if (err_cnt !== 8'd1 || err_addr !== 32'h8000_0000 || cpu_err !== 1'b1) begin
      bad++;
      $display("FAIL decode_err: cnt=%0d addr=%h err=%b want 1 80000000 1", err_cnt, err_addr, cpu_err);
    end
    idle(1);
  endtask

  // With the abort enabled a 30-cycle stall becomes a timeout; without it the access just waits.
  task automatic test_timeout();
    run_txn(1'b0, 32'hE000_0000, 32'h0, 4'hF, 30, 1'b0, 32'h0, 1'b1);
`ifdef MIO_TIMEOUT_EN
    total++;
    if (cpu_err !== 1'b1 || err_addr !== 32'hE000_0000) begin
      bad++;
      $display("FAIL timeout: err=%b addr=%h want 1 e0000000", cpu_err, err_addr);
    end
`else
    total++;
    if (cpu_err !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: err=%b want 0", cpu_err);
    end
`endif
    idle(1);
    run_txn(1'b0, 32'hE000_0000, 32'h0, 4'hF, TMO - 1, 1'b1, 32'hCAFE_0004, 1'b1);
    total++;
    if (cpu_err !== 1'b0 || cpu_rdata !== 32'hCAFE_0004) begin
      bad++;
      $display("FAIL ready_at_expiry: err=%b rdata=%h want 0 cafe0004", cpu_err, cpu_rdata);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] nibs [4] = '{4'h0, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 8; i++)
      run_txn(1'($urandom), {nibs[$urandom_range(0, 3)], 28'($urandom)}, $urandom,
              4'($urandom), $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h9000_0000, 32'h0, 4'h1, 0, 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'hF000_00F0, 32'h0, 4'h1, 0, 1'b0, 32'h0, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 6),
              1'b0, 32'h0, 1'b1);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 300; i++)
      run_txn(1'($urandom), {4'($urandom_range(1, 12)), 28'($urandom)}, $urandom,
              4'($urandom), 0, 1'b0, 32'h0, 1'b0);
    total++;
    if (err_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL err_saturate: cnt=%0d want 255", err_cnt);
    end
    idle(1);
  endtask

  task automatic test_reset_abort();
    int stall;
    stall = TMO_EN ? 3 : 12;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hE000_0100; cpu_wdata = '0; cpu_be = 4'hF;
    step();
    cpu_req = 1'b0;
    for (int c = 0; c < stall; c++) begin
      total++;
      if (slv_sel !== 4'b0100 || cpu_ack !== 1'b0) begin
        bad++;
        $display("FAIL stall: cyc=%0d sel=%b ack=%b want 0100 0", c, slv_sel, cpu_ack);
      end
      slv_ready = NSLV'($urandom) & 4'b1011;
      step();
    end
    #2 rst = 1'b0;
    #1;
    m_err_cnt = 0; m_err_addr = '0; m_rdata = '0;
    total++;
    if (slv_sel !== '0 || cpu_ack !== 1'b0 || err_cnt !== 8'h0 || err_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_abort: sel=%b ack=%b cnt=%0d addr=%h want 0 0 0 0",
               slv_sel, cpu_ack, err_cnt, err_addr);
    end
    slv_ready = '0;
    step();
    step();
    total++;
    if (cpu_ack !== 1'b0 || slv_sel !== '0) begin
      bad++;
      $display("FAIL reset_hold: ack=%b sel=%b want 0 0", cpu_ack, slv_sel);
    end
    rst = 1'b1;
    idle(1);
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, 1'b1, 32'h0BAD_F00D, 1'b0);
    total++;
    if (cpu_rdata !== 32'h0BAD_F00D || cpu_err !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: rdata=%h err=%b want 0badf00d 0", cpu_rdata, cpu_err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_err_saturate();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
